// File: rtl/aes_mixcol_iter.sv
// Iterative MixColumns / InvMixColumns engine over a 128-bit AES state.
// Transforms COLS_PER_CYCLE columns per clock in place; bypass passes the state through for the final round.
module aes_mixcol_iter #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] state_i,
    input  logic         inv_i,
    input  logic         bypass_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] state_o
);

    localparam int unsigned NUM_STEPS = (COLS_PER_CYCLE == 0) ? 1 : 4 / COLS_PER_CYCLE;
    localparam int unsigned CNT_W     = 2;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
            $error("aes_mixcol_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t               fsm;
    logic [CNT_W-1:0]   cnt;
    logic               inv_q;
    logic               byp_q;
    logic [127:0]       work;
    logic [127:0]       work_next;
    int unsigned        col_idx;

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the forward or inverse MixColumns matrix.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] p2 [4];
        logic [7:0] p3 [4];
        logic [7:0] p9 [4];
        logic [7:0] pb [4];
        logic [7:0] pd [4];
        logic [7:0] pe [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xt(a[r]);
            x4    = xt(x2);
            x8    = xt(x4);
            p2[r] = x2;
            p3[r] = x2 ^ a[r];
            p9[r] = x8 ^ a[r];
            pb[r] = x8 ^ x2 ^ a[r];
            pd[r] = x8 ^ x4 ^ a[r];
            pe[r] = x8 ^ x4 ^ x2;
        end
        for (int r = 0; r < 4; r++) begin
            if (inv) begin
                res[31-8*r -: 8] = pe[r] ^ pb[(r+1)%4] ^ pd[(r+2)%4] ^ p9[(r+3)%4];
            end else begin
                res[31-8*r -: 8] = p2[r] ^ p3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return res;
    endfunction

    // Working state with the current step's columns replaced by their transform.
    always_comb begin
        work_next = work;
        col_idx   = 0;
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
            col_idx = (32'(cnt) * COLS_PER_CYCLE + j) % 4;
            work_next[127-32*col_idx -: 32] = mix_col(work[127-32*col_idx -: 32], inv_q);
        end
    end

    assign ready_o = (fsm == IDLE) && !rst;
    assign state_o = work;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            valid_o <= 1'b0;
            work    <= '0;
            cnt     <= '0;
            inv_q   <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (valid_i) begin
                        work  <= state_i;
                        inv_q <= inv_i;
                        byp_q <= bypass_i;
                        cnt   <= '0;
                        fsm   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!byp_q) begin
                        work <= work_next;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_STEPS - 1)) begin
                        fsm     <= DONE;
                        valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    // Result is held until downstream takes it; no new accept in this cycle.
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        fsm     <= IDLE;
                    end
                end
                default: begin
                    fsm     <= IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mixcol_iter.sv
// Bench for aes_mixcol_iter: three instances (1, 2, 4 columns per cycle) checked against a
// matrix-level GF(2^8) model by a per-cycle monitor, plus directed literal vectors.
module tb_aes_mixcol_iter;

    localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_BYP   = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic         clk = 1'b0;
    logic [2:0]   rst;
    logic [2:0]   vi;
    logic [2:0]   ro;
    logic [2:0]   ii;
    logic [2:0]   bi;
    logic [2:0]   vo;
    logic [2:0]   ri;
    logic [127:0] si [3];
    logic [127:0] so [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    bit           inflight [3];
    bit           prev_rst [3];
    logic [127:0] expv     [3];
    int           due      [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mixcol_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .valid_i  (vi[g]),
            .ready_o  (ro[g]),
            .state_i  (si[g]),
            .inv_i    (ii[g]),
            .bypass_i (bi[g]),
            .valid_o  (vo[g]),
            .ready_i  (ri[g]),
            .state_o  (so[g])
        );
    end

    task automatic check(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, d, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // Circulant-matrix product per column, straight from the field definition.
    function automatic logic [127:0] model(input logic [127:0] st, input logic inv, input logic byp);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (byp) return st;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gf_mul(coef[j], st[127-32*c-8*((r+j)%4) -: 8]);
                end
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    // Per-cycle monitor: predicts handshake, latency and result for each instance.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                bit exp_valid;
                if (prev_rst[d]) check("state_after_rst", d, so[d], 128'h0);
                check("ready", d, 128'(ro[d]), 128'(!inflight[d] && !rst[d]));
                exp_valid = inflight[d] && (cyc >= due[d]);
                check("valid", d, 128'(vo[d]), 128'(exp_valid));
                if (exp_valid) check("state", d, so[d], expv[d]);
                prev_rst[d] = rst[d];
                if (rst[d]) begin
                    inflight[d] = 0;
                end else if (exp_valid && ri[d]) begin
                    inflight[d] = 0;
                end else if (!inflight[d] && vi[d]) begin
                    inflight[d] = 1;
                    expv[d]     = model(si[d], ii[d], bi[d]);
                    due[d]      = cyc + 1 + (4 >> d);
                end
            end
            cyc++;
        end
    end

    task automatic send(input int d, input logic [127:0] st, input logic inv, input logic byp);
        bit acc = 0;
        si[d] = st; ii[d] = inv; bi[d] = byp; vi[d] = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = ro[d];
            @(posedge clk); #1;
        end
        vi[d] = 1'b0;
        if (!acc) check("accept_timeout", d, 128'(acc), 128'(1));
    endtask

    task automatic recv(input int d, input int hold, output logic [127:0] res);
        bit got = 0;
        res = '0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = vo[d];
        end
        if (!got) begin
            check("valid_timeout", d, 128'(got), 128'(1));
        end else begin
            res = so[d];
            for (int n = 0; n < hold; n++) begin
                @(negedge clk);
                check("hold_valid", d, 128'(vo[d]), 128'(1));
                check("hold_state", d, so[d], res);
                check("hold_ready", d, 128'(ro[d]), 128'(0));
            end
            @(posedge clk); #1;
            ri[d] = 1'b1;
            @(posedge clk); #1;
            ri[d] = 1'b0;
        end
    endtask

    task automatic rand_test(input int d);
        logic [127:0] r, o1, o2;
        for (int n = 0; n < 1000; n++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            send(d, r, 1'b0, 1'b0);
            recv(d, 0, o1);
            send(d, o1, 1'b1, 1'b0);
            recv(d, 0, o2);
            check("roundtrip", d, o2, r);
        end
    endtask

    initial begin
        logic [127:0] res;
        rst = 3'b111; vi = '0; ri = '0; ii = '0; bi = '0;
        for (int d = 0; d < 3; d++) begin
            si[d] = '0; inflight[d] = 0; prev_rst[d] = 0; expv[d] = '0; due[d] = 0;
        end

        check("model_fwd", 0, model(V_PLAIN, 1'b0, 1'b0), V_MIXED);
        check("model_inv", 0, model(V_MIXED, 1'b1, 1'b0), V_PLAIN);
        check("model_byp", 0, model(V_BYP, 1'b1, 1'b1), V_BYP);

        @(posedge clk); #1;
        mon_en = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 3'b000;
        @(posedge clk); #1;

        // Literal vectors through every width.
        for (int d = 0; d < 3; d++) begin
            send(d, V_PLAIN, 1'b0, 1'b0);
            recv(d, 0, res);
            check("vec_fwd", d, res, V_MIXED);
            send(d, V_MIXED, 1'b1, 1'b0);
            recv(d, 0, res);
            check("vec_inv", d, res, V_PLAIN);
            send(d, V_BYP, 1'b1, 1'b1);
            recv(d, 0, res);
            check("vec_byp", d, res, V_BYP);
        end

        // Backpressure with valid_i held high through DONE.
        send(2, V_PLAIN, 1'b0, 1'b0);
        si[2] = V_MIXED; ii[2] = 1'b1; bi[2] = 1'b0; vi[2] = 1'b1;
        recv(2, 10, res);
        check("bp_first", 2, res, V_MIXED);
        @(posedge clk); #1;
        vi[2] = 1'b0;
        recv(2, 0, res);
        check("bp_second", 2, res, V_PLAIN);

        // Reset while at step 2 of a one-column-per-cycle block.
        send(0, V_PLAIN, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 0, 128'(vo[0]), 128'(0));
        check("mid_rst_state", 0, so[0], 128'h0);
        check("mid_rst_ready", 0, 128'(ro[0]), 128'(1));
        @(posedge clk); #1;
        send(0, V_PLAIN, 1'b0, 1'b0);
        recv(0, 0, res);
        check("after_rst_fwd", 0, res, V_MIXED);

        // Inputs churn while the block is in flight.
        send(1, V_PLAIN, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            ii[1] = ~ii[1];
            bi[1] = ~bi[1];
            si[1] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        recv(1, 0, res);
        check("isolation", 1, res, V_MIXED);

        fork
            rand_test(0);
            rand_test(1);
            rand_test(2);
        join

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
